// File: rtl/fir2d_kernel_engine.sv
// K x K 2D FIR engine: per-row systolic MAC chains, row sum, scale/round/saturate, double-buffered taps.
// Optional build macro FIR2D_ROUND_EN: round half up in the scaling stage instead of truncating.
module fir2d_kernel_engine #(
  parameter int K         = 5,
  parameter int PIX_W     = 8,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [K*PIX_W-1:0]       pixels,
  input  logic                     coeff_we,
  input  logic [5:0]               coeff_addr,
  input  logic signed [COEF_W-1:0] coeff_data,
  input  logic                     coeff_commit,
  output logic [PIX_W-1:0]         out_pixel,
  output logic                     out_valid,
  output logic                     busy
);

  localparam int NTAP  = K * K;
  localparam int LAT   = K + 3;
  localparam int ACC_W = PIX_W + COEF_W + 1 + $clog2(NTAP);
  localparam int AW    = $clog2(NTAP);
  localparam int CNT_W = $clog2(LAT + 1);
  localparam int DLY   = 2 * (K - 1);
  localparam int CTR   = (K / 2) * K + K / 2;

  localparam logic [COEF_W-1:0]        UNITY   = COEF_W'(1 << COEF_FRAC);
  localparam logic signed [ACC_W-1:0]  PIX_MAX = ACC_W'((1 << PIX_W) - 1);
`ifdef FIR2D_ROUND_EN
  localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(1 << (COEF_FRAC - 1));
`endif

  // Coefficient bank: shadow is written by software, active feeds the multipliers.
  logic [NTAP-1:0][COEF_W-1:0] shadow;
  logic [NTAP-1:0][COEF_W-1:0] active;
  logic [NTAP-1:0][COEF_W-1:0] shadow_nxt;
  logic                        addr_ok;

  assign addr_ok = (int'(coeff_addr) < NTAP);

  // A same-cycle write is folded in here so the commit below picks it up.
  always_comb begin
    shadow_nxt = shadow;
    if (coeff_we && addr_ok) shadow_nxt[coeff_addr[AW-1:0]] = coeff_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      active      <= '0;
      shadow[CTR] <= UNITY;
      active[CTR] <= UNITY;
    end else begin
      shadow <= shadow_nxt;
      if (coeff_commit) active <= shadow_nxt;
    end
  end

  // Flush timer and valid delay line.
  logic [CNT_W-1:0] flush_cnt;
  logic [LAT-1:0]   vld_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
      vld_dly   <= '0;
    end else begin
      vld_dly <= {vld_dly[LAT-2:0], in_valid};
      if (coeff_commit)          flush_cnt <= CNT_W'(LAT);
      else if (flush_cnt != '0)  flush_cnt <= flush_cnt - 1'b1;
    end
  end

  assign busy      = (flush_cnt != '0);
  assign out_valid = vld_dly[LAT-1] & ~busy;

  function automatic logic signed [ACC_W-1:0] tap_product(
    input logic [PIX_W-1:0]  px,
    input logic [COEF_W-1:0] h
  );
    logic signed [ACC_W-1:0] px_s;
    logic signed [ACC_W-1:0] h_s;
    px_s = ACC_W'({1'b0, px});
    h_s  = ACC_W'($signed(h));
    return px_s * h_s;
  endfunction

  logic [K-1:0][PIX_W-1:0]          row_px;
  logic [K-1:0][DLY-1:0][PIX_W-1:0] xdl;
  logic [K-1:0][K-1:0][ACC_W-1:0]   psum;
  logic signed [ACC_W-1:0]          row_total;
  logic signed [ACC_W-1:0]          acc_q;
  logic signed [ACC_W-1:0]          scaled_q;

  for (genvar r = 0; r < K; r++) begin : g_row
    assign row_px[r] = pixels[r*PIX_W +: PIX_W];
  end

  // Stage c of a row chain adds tap c; its sample must lag the input by 2c
  // cycles to line up with the partial arriving from stage c-1.
  always_ff @(posedge clk) begin
    for (int r = 0; r < K; r++) begin
      xdl[r][0] <= row_px[r];
      for (int d = 1; d < DLY; d++) xdl[r][d] <= xdl[r][d-1];
      psum[r][0] <= tap_product(row_px[r], active[r*K]);
      for (int c = 1; c < K; c++)
        psum[r][c] <= psum[r][c-1] + tap_product(xdl[r][2*c-1], active[r*K+c]);
    end
  end

  always_comb begin
    row_total = '0;
    for (int r = 0; r < K; r++) row_total = row_total + $signed(psum[r][K-1]);
  end

  always_ff @(posedge clk) begin
    acc_q <= row_total;
`ifdef FIR2D_ROUND_EN
    scaled_q <= (acc_q + RND) >>> COEF_FRAC;
`else
    scaled_q <= acc_q >>> COEF_FRAC;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)                      out_pixel <= '0;
    else if (scaled_q < 0)        out_pixel <= '0;
    else if (scaled_q > PIX_MAX)  out_pixel <= PIX_MAX[PIX_W-1:0];
    else                          out_pixel <= scaled_q[PIX_W-1:0];
  end

endmodule

// File: tb/tb_fir2d_kernel_engine.sv
// Directed bench for fir2d_kernel_engine (K=5): identity, kernel load, saturation, rounding, bank edge cases, valid gating.
module tb_fir2d_kernel_engine;
  localparam int K         = 5;
  localparam int PIX_W     = 8;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 8;
  localparam int LAT       = K + 3;
  localparam int CTR       = 12;
`ifdef FIR2D_ROUND_EN
  localparam int EXP_R3   = 2;
  localparam int EXP_R255 = 128;
`else
  localparam int EXP_R3   = 1;
  localparam int EXP_R255 = 127;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic [K*PIX_W-1:0]       pixels;
  logic                     coeff_we;
  logic [5:0]               coeff_addr;
  logic signed [COEF_W-1:0] coeff_data;
  logic                     coeff_commit;
  logic [PIX_W-1:0]         out_pixel;
  logic                     out_valid;
  logic                     busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fir2d_kernel_engine #(.K(K), .PIX_W(PIX_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pixels(pixels),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .coeff_commit(coeff_commit), .out_pixel(out_pixel), .out_valid(out_valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input logic [7:0] other, input logic [7:0] centre);
    pixels = {other, other, centre, other, other};
  endtask

  task automatic write_tap(input logic [5:0] addr, input logic [15:0] data);
    coeff_we   = 1'b1;
    coeff_addr = addr;
    coeff_data = data;
    step();
    coeff_we   = 1'b0;
  endtask

  task automatic commit();
    coeff_commit = 1'b1;
    step();
    coeff_commit = 1'b0;
  endtask

  // Centre-only kernel, committed, then wait out the flush.
  task automatic load_centre(input logic [15:0] val);
    for (int a = 0; a < K*K; a++) write_tap(6'(a), (a == CTR) ? val : 16'h0000);
    commit();
    repeat (LAT) step();
  endtask

  initial begin
    int n;
    logic [4:0] pat;
    rst = 1'b1; in_valid = 1'b0; pixels = '0;
    coeff_we = 1'b0; coeff_addr = '0; coeff_data = '0; coeff_commit = 1'b0;
    repeat (3) step();
    check("rst_pixel", out_pixel, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Identity kernel: centre row ramp appears two columns late.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      set_rows(8'd255, 8'(10 * (i + 1)));
      step();
      n = i - 7;
      if (n < 0) check("id_valid_early", out_valid, 0);
      else begin
        check("id_valid", out_valid, 1);
        if (n >= 2) check("id_pixel", out_pixel, 10 * (n - 1));
      end
    end

    // All-ones kernel on constant 7.
    set_rows(8'd7, 8'd7);
    for (int a = 0; a < K*K; a++) write_tap(6'(a), 16'h0100);
    commit();
    for (int j = 1; j <= LAT; j++) begin
      check("flush_busy", busy, 1);
      check("flush_valid", out_valid, 0);
      step();
    end
    for (int j = 0; j < 4; j++) begin
      check("ones_busy", busy, 0);
      check("ones_valid", out_valid, 1);
      check("ones_pixel", out_pixel, 175);
      step();
    end

    // Saturation and plain scaling.
    set_rows(8'd100, 8'd100);
    load_centre(16'h1000);
    check("sat_hi", out_pixel, 255);
    check("sat_hi_valid", out_valid, 1);
    load_centre(16'hFF00);
    check("sat_lo", out_pixel, 0);
    load_centre(16'h0200);
    check("scale_x2", out_pixel, 200);

    // Rounding of a half-weight tap.
    set_rows(8'd3, 8'd3);
    load_centre(16'h0080);
    check("round_3", out_pixel, EXP_R3);
    set_rows(8'd255, 8'd255);
    repeat (LAT + K) step();
    check("round_255", out_pixel, EXP_R255);

    // Out-of-range tap writes must not touch the bank.
    write_tap(6'd25, 16'h7FFF);
    write_tap(6'd44, 16'h7FFF);
    write_tap(6'd63, 16'h7FFF);
    commit();
    repeat (LAT) step();
    check("ign_pixel", out_pixel, EXP_R255);
    check("ign_valid", out_valid, 1);

    // Write and commit on the same edge.
    set_rows(8'd50, 8'd50);
    repeat (K) step();
    coeff_we = 1'b1; coeff_addr = 6'd12; coeff_data = 16'h0300; coeff_commit = 1'b1;
    step();
    coeff_we = 1'b0; coeff_commit = 1'b0;
    repeat (LAT) step();
    check("wc_pixel", out_pixel, 150);
    check("wc_valid", out_valid, 1);

    // Second commit three cycles into a flush extends it.
    commit();
    for (int k = 1; k <= 11; k++) begin
      check("dbl_valid_low", out_valid, 0);
      if (k == 3) coeff_commit = 1'b1;
      step();
      coeff_commit = 1'b0;
    end
    check("dbl_valid_end", out_valid, 1);
    check("dbl_busy_end", busy, 0);
    check("dbl_pixel", out_pixel, 150);

    // in_valid pattern 1,0,1,1,0 reappears LAT cycles later.
    pat = 5'b01101;
    for (int i = 0; i < 15; i++) begin
      in_valid = (i < 5) ? pat[i] : 1'b0;
      step();
      n = i - 7;
      check("vpat", out_valid, (n < 0) ? 1 : ((n < 5) ? pat[n] : 0));
    end

    // Mid-stream reset.
    in_valid = 1'b1;
    repeat (LAT + 1) step();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    step();
    check("rstmid_valid", out_valid, 0);
    check("rstmid_pixel", out_pixel, 0);
    rst = 1'b0; in_valid = 1'b0;
    set_rows(8'd255, 8'd60);
    for (int j = 0; j < 3; j++) begin
      step();
      check("rst_idle_valid", out_valid, 0);
    end
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1;
      step();
      check("rst_recover_valid", out_valid, (j >= 7) ? 1 : 0);
    end
    check("rst_ident_pixel", out_pixel, 60);

    // Reset clears a running flush.
    commit();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    check("rst_busy_clr", busy, 0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
